// File: rtl/counter_mod_n_if.sv
// Handshake and status bundle for counter_mod_n.
// Master drives the controls; slave returns the counts and status.
interface counter_mod_n_if #(
  parameter int WIDTH = 7
);
  logic             i_start;
  logic             i_en;
  logic             i_up;
  logic             i_oneshot;
  logic             i_load;
  logic [WIDTH-1:0] i_load_val;
  logic             i_clear;
  logic [WIDTH-1:0] o_cnt;
  logic [WIDTH-1:0] o_cnt_always;
  logic             o_tc;
  logic             o_done;
  logic             o_busy;

  modport master (
    output i_start, i_en, i_up, i_oneshot,
    output i_load, i_load_val, i_clear,
    input  o_cnt, o_cnt_always, o_tc,
    input  o_done, o_busy
  );

  modport slave (
    input  i_start, i_en, i_up, i_oneshot,
    input  i_load, i_load_val, i_clear,
    output o_cnt, o_cnt_always, o_tc,
    output o_done, o_busy
  );
endinterface

// File: rtl/counter_mod_n.sv
// Modulo-N counter with run control, direction, one-shot/wrap,
// parallel load, terminal-count pulse and free-running reference.
module counter_mod_n #(
  parameter int WIDTH = 7,
  parameter int MOD   = 100
) (
  input logic            clk,
  input logic            reset_n,
  counter_mod_n_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic [WIDTH-1:0] MAXV = WIDTH'(MOD - 1);
  localparam logic [WIDTH-1:0] ZERO = '0;
  localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] ref_q, ref_d;
  logic             tc_q, tc_d;
  logic             busy, done;
  logic             term, step;
  logic [WIDTH-1:0] ld_val;

  assign term   = bus.i_up ? (cnt_q == MAXV) : (cnt_q == ZERO);
  assign step   = (state_q == RUN) && bus.i_en && !bus.i_load;
  assign ld_val = (bus.i_load_val > MAXV) ? MAXV : bus.i_load_val;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (bus.i_clear) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: if (bus.i_start) state_d = RUN;
        RUN:  if (step && term && bus.i_oneshot) state_d = DONE;
        DONE: if (bus.i_start) state_d = RUN;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    busy = (state_q == RUN);
    done = (state_q == DONE);
  end

  // Load beats the DONE reload; the step only runs with no load pending.
  always_comb begin
    cnt_d = cnt_q;
    tc_d  = 1'b0;
    if (bus.i_clear) begin
      cnt_d = ZERO;
    end else if (bus.i_load) begin
      cnt_d = ld_val;
    end else if (state_q == DONE && bus.i_start) begin
      cnt_d = bus.i_up ? ZERO : MAXV;
    end else if (step) begin
      if (term) begin
        tc_d = 1'b1;
        if (!bus.i_oneshot) begin
          cnt_d = bus.i_up ? ZERO : MAXV;
        end
      end else begin
        cnt_d = bus.i_up ? cnt_q + ONE : cnt_q - ONE;
      end
    end
  end

  always_comb begin
    ref_d = (ref_q == MAXV) ? ZERO : ref_q + ONE;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt_q <= '0;
      ref_q <= '0;
      tc_q  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      ref_q <= ref_d;
      tc_q  <= tc_d;
    end
  end

  assign bus.o_cnt        = cnt_q;
  assign bus.o_cnt_always = ref_q;
  assign bus.o_tc         = tc_q;
  assign bus.o_done       = done;
  assign bus.o_busy       = busy;

endmodule

// File: tb/tb_counter_mod_n.sv
// Directed bench for counter_mod_n, WIDTH=7 MOD=100.
// Linear stimulus with immediate assertions at each check.
module tb_counter_mod_n;

  logic clk;
  logic reset_n;
  int   n_cmp;
  int   n_bad;
  int   exp_ref;
  int   tc_seen;

  counter_mod_n_if #(.WIDTH(7)) bus ();

  counter_mod_n #(
    .WIDTH(7),
    .MOD  (100)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    logic r;
    r = reset_n;
    @(posedge clk);
    #1;
    exp_ref = r ? (exp_ref + 1) % 100 : 0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input int cnt,
                         input int tc, input int dn, input int bz);
    chk({tag, ".cnt"}, int'(bus.o_cnt), cnt);
    chk({tag, ".tc"}, int'(bus.o_tc), tc);
    chk({tag, ".done"}, int'(bus.o_done), dn);
    chk({tag, ".busy"}, int'(bus.o_busy), bz);
    chk({tag, ".ref"}, int'(bus.o_cnt_always), exp_ref);
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    exp_ref = 0;
    reset_n = 1'b0;
    bus.i_start = 1'b0;
    bus.i_en = 1'b0;
    bus.i_up = 1'b1;
    bus.i_oneshot = 1'b0;
    bus.i_load = 1'b0;
    bus.i_load_val = '0;
    bus.i_clear = 1'b0;

    // 1: reset and free-running reference
    ticks(2);
    reset_n = 1'b1;
    chk_all("rst", 0, 0, 0, 0);
    ticks(99);
    chk("ref99", int'(bus.o_cnt_always), 99);
    tick();
    chk("ref100", int'(bus.o_cnt_always), 0);
    chk_all("idle", 0, 0, 0, 0);

    // 2: wrap up
    bus.i_start = 1'b1;
    bus.i_en = 1'b1;
    tick();
    bus.i_start = 1'b0;
    chk_all("start", 0, 0, 0, 1);
    ticks(99);
    chk_all("up99", 99, 0, 0, 1);
    tick();
    chk_all("wrap0", 0, 1, 0, 1);
    tick();
    chk_all("wrap1", 1, 0, 0, 1);
    tc_seen = 0;
    for (int i = 0; i < 99; i++) begin
      tick();
      if (bus.o_tc) tc_seen++;
    end
    chk("period.tc", int'(bus.o_tc), 1);
    chk("period.n", tc_seen, 1);
    chk("period.cnt", int'(bus.o_cnt), 0);

    // 3: one-shot up
    bus.i_clear = 1'b1;
    tick();
    bus.i_clear = 1'b0;
    chk_all("clr3", 0, 0, 0, 0);
    bus.i_oneshot = 1'b1;
    bus.i_start = 1'b1;
    tick();
    bus.i_start = 1'b0;
    ticks(99);
    chk_all("os99", 99, 0, 0, 1);
    tick();
    chk_all("osdone", 99, 1, 1, 0);
    tick();
    chk_all("oshold", 99, 0, 1, 0);
    bus.i_start = 1'b1;
    tick();
    bus.i_start = 1'b0;
    chk_all("osrestart", 0, 0, 0, 1);

    // 4: down with load from IDLE
    bus.i_clear = 1'b1;
    tick();
    bus.i_clear = 1'b0;
    bus.i_oneshot = 1'b0;
    bus.i_en = 1'b0;
    bus.i_load = 1'b1;
    bus.i_load_val = 7'd5;
    bus.i_start = 1'b1;
    tick();
    bus.i_load = 1'b0;
    bus.i_start = 1'b0;
    bus.i_up = 1'b0;
    bus.i_en = 1'b1;
    chk_all("ld5", 5, 0, 0, 1);
    for (int v = 4; v >= 0; v--) begin
      tick();
      chk("down", int'(bus.o_cnt), v);
    end
    chk("down0.tc", int'(bus.o_tc), 0);
    tick();
    chk_all("down99", 99, 1, 0, 1);

    // 5: clamp and enable gating
    bus.i_load = 1'b1;
    bus.i_load_val = 7'd120;
    bus.i_up = 1'b1;
    tick();
    bus.i_load = 1'b0;
    chk_all("clamp", 99, 0, 0, 1);
    tick();
    chk_all("en1", 0, 1, 0, 1);
    bus.i_en = 1'b0;
    tick();
    chk_all("en0a", 0, 0, 0, 1);
    tick();
    chk_all("en0b", 0, 0, 0, 1);
    bus.i_en = 1'b1;
    tick();
    chk_all("en1b", 1, 0, 0, 1);

    // 6: mid-run clear beats load, then mid-run reset
    ticks(41);
    chk("at42", int'(bus.o_cnt), 42);
    bus.i_clear = 1'b1;
    bus.i_load = 1'b1;
    bus.i_load_val = 7'd7;
    tick();
    bus.i_clear = 1'b0;
    bus.i_load = 1'b0;
    chk_all("clr42", 0, 0, 0, 0);
    bus.i_start = 1'b1;
    tick();
    bus.i_start = 1'b0;
    ticks(10);
    chk_all("at10", 10, 0, 0, 1);
    reset_n = 1'b0;
    tick();
    chk_all("midrst", 0, 0, 0, 0);
    chk("midrst.ref0", int'(bus.o_cnt_always), 0);
    reset_n = 1'b1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
